// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - register-file writeback FIFO with optional bypass lookup
// Define WBQ_BYPASS_EN to build the hit/fwd_dat lookup; otherwise those outputs are tied to 0.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq_valid,
  input  logic [4:0]                 enq_reg,
  input  logic [31:0]                enq_dat,
  output logic                       enq_ready,
  input  logic                       hold,
  output logic                       write,
  output logic [4:0]                 w_reg,
  output logic [31:0]                w_dat,
  input  logic [4:0]                 q_reg0,
  input  logic [4:0]                 q_reg1,
  output logic                       hit0,
  output logic                       hit1,
  output logic [31:0]                fwd_dat0,
  output logic [31:0]                fwd_dat1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    regs [DEPTH];
  logic [31:0]   dats [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          nonempty;

  assign nonempty  = (count != '0);
  assign enq_ready = (count != CW'(DEPTH));
  // r0 requests are acknowledged but never stored
  assign push      = enq_valid && enq_ready && (enq_reg != 5'd0);
  assign write     = nonempty && !hold;
  assign pop       = write;
  assign w_reg     = nonempty ? regs[rptr] : 5'd0;
  assign w_dat     = nonempty ? dats[rptr] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      regs[wptr] <= enq_reg;
      dats[wptr] <= enq_dat;
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [32:0] lookup(input logic [4:0] q);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if ((CW'(i) < count) && (q != 5'd0) && (regs[idx] == q))
        r = {1'b1, dats[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {hit0, fwd_dat0} = lookup(q_reg0);
    {hit1, fwd_dat1} = lookup(q_reg1);
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{q_reg0, q_reg1};
  assign hit0     = 1'b0;
  assign hit1     = 1'b0;
  assign fwd_dat0 = 32'd0;
  assign fwd_dat1 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_valid;
  logic [4:0]  enq_reg;
  logic [31:0] enq_dat;
  logic        enq_ready;
  logic        hold;
  logic        write;
  logic [4:0]  w_reg;
  logic [31:0] w_dat;
  logic [4:0]  q_reg0, q_reg1;
  logic        hit0, hit1;
  logic [31:0] fwd_dat0, fwd_dat1;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef WBQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_reg(enq_reg), .enq_dat(enq_dat), .enq_ready(enq_ready),
    .hold(hold), .write(write), .w_reg(w_reg), .w_dat(w_dat),
    .q_reg0(q_reg0), .q_reg1(q_reg1), .hit0(hit0), .hit1(hit1),
    .fwd_dat0(fwd_dat0), .fwd_dat1(fwd_dat1), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] r, input logic [31:0] d);
    enq_valid = 1'b1;
    enq_reg   = r;
    enq_dat   = d;
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_reg = '0; enq_dat = '0;
    hold = 1'b0; q_reg0 = '0; q_reg1 = '0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_write", 32'(write), 0);
    check("rst_ready", 32'(enq_ready), 1);
    check("rst_hit0", 32'(hit0), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // single request latency
    enq(5'd5, 32'hDEAD_BEEF);
    check("lat_write", 32'(write), 1);
    check("lat_wreg", 32'(w_reg), 5);
    check("lat_wdat", w_dat, 32'hDEAD_BEEF);
    step();
    check("lat_count0", 32'(count), 0);
    check("lat_write0", 32'(write), 0);
    check("lat_wdat0", w_dat, 0);

    // fill while held, then drain in order
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) enq(5'(k), 32'(k * 32'h11));
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(enq_ready), 0);
    check("full_write", 32'(write), 0);
    hold = 1'b0;
    enq_valid = 1'b1; enq_reg = 5'd9; enq_dat = 32'h99;
    check("full_nopop_ready", 32'(enq_ready), 0);
    step();
    enq_valid = 1'b0;
    check("full_reject_count", 32'(count), 3);
    check("drain1_wreg", 32'(w_reg), 2);
    for (int k = 2; k <= 4; k++) begin
      check("drain_write", 32'(write), 1);
      check("drain_wreg", 32'(w_reg), 32'(k));
      check("drain_wdat", w_dat, 32'(k * 32'h11));
      step();
    end
    check("drain_empty", 32'(count), 0);
    check("drain_nowrite", 32'(write), 0);

    // r0 discarded
    enq(5'd0, 32'h1234);
    check("r0_count", 32'(count), 0);
    check("r0_write", 32'(write), 0);
    step();
    check("r0_write2", 32'(write), 0);

    // bypass lookup: youngest match, accept-cycle invisibility
    hold = 1'b1;
    enq(5'd7, 32'hA);
    enq(5'd7, 32'hB);
    q_reg0 = 5'd7; q_reg1 = 5'd3;
    #1;
    check("byp_hit0", 32'(hit0), 32'(BYP));
    check("byp_fwd0", fwd_dat0, BYP ? 32'hB : 32'h0);
    check("byp_hit1", 32'(hit1), 0);
    enq_valid = 1'b1; enq_reg = 5'd3; enq_dat = 32'hC;
    #1;
    check("byp_same_cycle", 32'(hit1), 0);
    step();
    enq_valid = 1'b0;
    check("byp_next_hit1", 32'(hit1), 32'(BYP));
    check("byp_next_fwd1", fwd_dat1, BYP ? 32'hC : 32'h0);
    check("byp_count", 32'(count), 3);
    q_reg0 = 5'd0;
    #1;
    check("byp_r0_nohit", 32'(hit0), 0);
    q_reg0 = 5'd7;
    hold = 1'b0;
    #1;
    check("byp_head_write", 32'(write), 1);
    check("byp_head_hit0", 32'(hit0), 32'(BYP));
    check("byp_head_fwd0", fwd_dat0, BYP ? 32'hB : 32'h0);
    step(); step();
    check("byp_after_pop7", 32'(hit0), 0);
    step();
    check("byp_empty", 32'(count), 0);
    q_reg0 = '0; q_reg1 = '0;

    // steady state with simultaneous accept and pop across pointer wrap
    hold = 1'b1;
    enq(5'd10, 32'h100);
    enq(5'd11, 32'h101);
    hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      enq_valid = 1'b1; enq_reg = 5'(12 + k); enq_dat = 32'h102 + 32'(k);
      #1;
      check("ss_count", 32'(count), 2);
      check("ss_write", 32'(write), 1);
      check("ss_wreg", 32'(w_reg), 32'(10 + k));
      check("ss_wdat", w_dat, 32'h100 + 32'(k));
      step();
    end
    enq_valid = 1'b0;
    check("ss_tail_wreg0", 32'(w_reg), 20);
    step();
    check("ss_tail_wreg1", 32'(w_reg), 21);
    step();
    check("ss_tail_empty", 32'(count), 0);

    // asynchronous reset with entries pending
    hold = 1'b1;
    enq(5'd1, 32'h1);
    enq(5'd2, 32'h2);
    enq(5'd3, 32'h3);
    check("ar_pre_count", 32'(count), 3);
    #2;
    hold = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_write", 32'(write), 0);
    check("ar_ready", 32'(enq_ready), 1);
    step();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ar_post_write", 32'(write), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
